// File: rtl/proc_pkg.sv
// Shared encodings for the 16-bit processor control unit:
// opcodes, bus sources, ALU ops, timestep states and the IR layout.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  localparam logic [3:0] BUS_G    = 4'd8;
  localparam logic [3:0] BUS_DIN  = 4'd9;
  localparam logic [3:0] BUS_IDLE = 4'd15;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
  } ir_t;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// Control-unit side bundle: run/instruction input and the
// datapath enables, bus select and ALU opcode it drives.
interface proc_ctrl_fsm_if #(
  parameter int DATA_W = 16
);
  logic              run;
  logic [DATA_W-1:0] din;
  logic              ir_en;
  logic [7:0]        r_en;
  logic              a_en;
  logic              g_en;
  logic [3:0]        bus_sel;
  logic [1:0]        alu_op;
  logic              done;

  modport master (
    input  run, din,
    output ir_en, r_en, a_en, g_en,
    output bus_sel, alu_op, done
  );

  modport slave (
    output run, din,
    input  ir_en, r_en, a_en, g_en,
    input  bus_sel, alu_op, done
  );
endinterface

// File: rtl/proc_dec3to8.sv
// 3-to-8 one-hot decoder with enable;
// produces the register load enables.
module proc_dec3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit: owns IR, steps T0..T3 and
// decodes datapath enables, bus select and ALU op.
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input logic              clk,
  input logic              reset,
  proc_ctrl_fsm_if.master  bus
);

  state_t     state;
  ir_t        ir;
  logic       r_we;
  logic [2:0] r_idx;
  logic       unused_din;

  assign unused_din = ^bus.din;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      unique case (state)
        T0: begin
          if (bus.run) begin
            ir    <= bus.din[DATA_W-1 -: 9];
            state <= T1;
          end
        end
        T1:      state <= is_alu(ir.op) ? T2 : T0;
        T2:      state <= T3;
        T3:      state <= T0;
        default: state <= T0;
      endcase
    end
  end

  always_comb begin
    bus.ir_en   = 1'b0;
    bus.a_en    = 1'b0;
    bus.g_en    = 1'b0;
    bus.bus_sel = BUS_IDLE;
    bus.alu_op  = ALU_ADD;
    bus.done    = 1'b0;
    r_we        = 1'b0;
    r_idx       = ir.rx;
    if (!reset) begin
      unique case (state)
        T0: bus.ir_en = bus.run;
        T1: begin
          unique case (1'b1)
            ir.op == OP_MV: begin
              bus.bus_sel = {1'b0, ir.ry};
              r_we        = 1'b1;
              bus.done    = 1'b1;
            end
            ir.op == OP_MVI: begin
              bus.bus_sel = BUS_DIN;
              r_we        = 1'b1;
              bus.done    = 1'b1;
            end
            is_alu(ir.op): begin
              bus.bus_sel = {1'b0, ir.rx};
              bus.a_en    = 1'b1;
            end
            default: bus.done = 1'b1;
          endcase
        end
        T2: begin
          bus.bus_sel = {1'b0, ir.ry};
          bus.g_en    = 1'b1;
          unique case (1'b1)
            ir.op == OP_SUB: bus.alu_op = ALU_SUB;
            ir.op == OP_AND: bus.alu_op = ALU_AND;
            default:         bus.alu_op = ALU_ADD;
          endcase
        end
        T3: begin
          bus.bus_sel = BUS_G;
          r_we        = 1'b1;
          bus.done    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  proc_dec3to8 u_dec (
    .idx    (r_idx),
    .en     (r_we),
    .onehot (bus.r_en)
  );

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: directed cases plus random traffic
// checked every cycle against a per-instruction schedule model.
module tb_proc_ctrl_fsm;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  proc_ctrl_fsm_if #(.DATA_W(16)) bus ();

  proc_ctrl_fsm #(.DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // {ir_en, r_en, a_en, g_en, bus_sel, alu_op, done}
  typedef logic [17:0] vec_t;
  vec_t sched[$];

  function automatic vec_t mk(logic ir, logic [7:0] re, logic a,
                              logic g, logic [3:0] bs,
                              logic [1:0] op, logic d);
    return {ir, re, a, g, bs, op, d};
  endfunction

  function automatic vec_t expected();
    if (reset) return mk(0, 0, 0, 0, 15, 0, 0);
    if (sched.size() == 0) return mk(bus.run, 0, 0, 0, 15, 0, 0);
    return sched[0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model advance: an accepted instruction becomes a list of
  // cycle outputs, consumed one per clock until it runs dry.
  always @(posedge clk) begin
    int op, rx, ry;
    logic [7:0] oh;
    if (reset) begin
      sched.delete();
    end else if (sched.size() > 0) begin
      void'(sched.pop_front());
    end else if (bus.run) begin
      op = int'(bus.din[15:13]);
      rx = int'(bus.din[12:10]);
      ry = int'(bus.din[9:7]);
      oh = 8'(1 << rx);
      if (op == 0) begin
        sched.push_back(mk(0, oh, 0, 0, 4'(ry), 0, 1));
      end else if (op == 1) begin
        sched.push_back(mk(0, oh, 0, 0, 9, 0, 1));
      end else if (op <= 4) begin
        sched.push_back(mk(0, 0, 1, 0, 4'(rx), 0, 0));
        sched.push_back(mk(0, 0, 0, 1, 4'(ry), 2'(op - 2), 0));
        sched.push_back(mk(0, oh, 0, 0, 8, 0, 1));
      end else begin
        sched.push_back(mk(0, 0, 0, 0, 15, 0, 1));
      end
    end
  end

  always @(negedge clk) begin
    vec_t act;
    act = {bus.ir_en, bus.r_en, bus.a_en, bus.g_en,
           bus.bus_sel, bus.alu_op, bus.done};
    chk("model_cmp", 32'(act), 32'(expected()));
    chk("r_en_onehot0", 32'($countones(bus.r_en) <= 1), 1);
  end

  task automatic cyc(logic r, logic rn, logic [15:0] d);
    @(posedge clk);
    #1;
    reset   = r;
    bus.run = rn;
    bus.din = d;
    #3;
  endtask

  initial begin
    bus.run = 1'b0;
    bus.din = '0;

    cyc(1, 0, 16'h0000);
    chk("rst_bus_sel", bus.bus_sel, 15);
    chk("rst_done", bus.done, 0);
    cyc(1, 1, 16'h2800);
    chk("rst_ir_en_forced", bus.ir_en, 0);

    cyc(0, 1, 16'h2800);
    chk("mvi_t0_ir_en", bus.ir_en, 1);
    cyc(0, 0, 16'h00A5);
    chk("mvi_t1_bus", bus.bus_sel, 9);
    chk("mvi_t1_r_en", bus.r_en, 8'h04);
    chk("mvi_t1_done", bus.done, 1);
    cyc(0, 0, 16'h0000);
    chk("mvi_back_t0_bus", bus.bus_sel, 15);
    chk("mvi_back_t0_done", bus.done, 0);

    cyc(0, 1, 16'h1500);
    cyc(0, 0, 16'h0000);
    chk("mv_t1_bus", bus.bus_sel, 2);
    chk("mv_t1_r_en", bus.r_en, 8'h20);
    chk("mv_t1_done", bus.done, 1);
    chk("mv_t1_ag", {bus.a_en, bus.g_en}, 0);

    cyc(0, 1, 16'h4580);
    cyc(0, 0, 16'h0000);
    chk("add_t1_bus", bus.bus_sel, 1);
    chk("add_t1_a_en", bus.a_en, 1);
    chk("add_t1_done", bus.done, 0);
    cyc(0, 0, 16'h0000);
    chk("add_t2_bus", bus.bus_sel, 3);
    chk("add_t2_g_en", bus.g_en, 1);
    chk("add_t2_alu", bus.alu_op, 0);
    cyc(0, 0, 16'h0000);
    chk("add_t3_bus", bus.bus_sel, 8);
    chk("add_t3_r_en", bus.r_en, 8'h02);
    chk("add_t3_done", bus.done, 1);

    cyc(0, 1, 16'h7C00);
    cyc(0, 1, 16'h2800);
    chk("sub_t1_run_ignored", bus.ir_en, 0);
    cyc(0, 1, 16'h2800);
    chk("sub_t2_alu", bus.alu_op, 1);
    chk("sub_t2_bus", bus.bus_sel, 0);
    cyc(0, 1, 16'h2800);
    chk("sub_t3_r_en", bus.r_en, 8'h80);
    chk("sub_t3_done", bus.done, 1);
    cyc(0, 1, 16'h2800);
    chk("back_to_back_ir_en", bus.ir_en, 1);
    cyc(0, 0, 16'h0011);
    chk("b2b_mvi_done", bus.done, 1);

    cyc(0, 1, 16'h4580);
    cyc(0, 0, 16'h0000);
    cyc(1, 0, 16'h0000);
    chk("rst_mid_g_en", bus.g_en, 0);
    chk("rst_mid_bus", bus.bus_sel, 15);
    cyc(0, 0, 16'h0000);
    chk("rst_mid_after_r_en", bus.r_en, 0);
    chk("rst_mid_after_bus", bus.bus_sel, 15);
    chk("rst_mid_after_done", bus.done, 0);

    cyc(0, 1, 16'hE000);
    cyc(0, 0, 16'h0000);
    chk("rsv_t1_done", bus.done, 1);
    chk("rsv_t1_en", {bus.r_en, bus.a_en, bus.g_en}, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 16'(($urandom)));
      chk("idle_ir_en", bus.ir_en, 0);
      chk("idle_done", bus.done, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 6),
          16'($urandom));
    end

    cyc(0, 0, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
